// File: rtl/screen_pkg.sv
// Shared framebuffer/tile geometry, address type and reader states.
// Imported by the tile reader, its scan counter and its interface.
package screen_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CHAR_WIDTH    = 20;
  localparam int CHAR_HEIGHT   = 30;
  localparam int ADDR_W        = 19;
  localparam int TILE_BITS     = CHAR_WIDTH * CHAR_HEIGHT;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/tile_reader_if.sv
// Tile reader bus: start/ready request side, framebuffer read port, tile result.
// master = requester + memory model, slave = tile_reader.
interface tile_reader_if;
  import screen_pkg::*;

  addr_t                top_left_corner_address;
  logic                 start_reading_tile;
  logic                 ready;
  addr_t                mem_raddr;
  logic                 mem_renable;
  logic [2:0]           mem_rdata;
  logic [TILE_BITS-1:0] tile_bits;
  logic                 tile_valid;

  modport master (
    output top_left_corner_address,
    output start_reading_tile,
    output mem_rdata,
    input  ready,
    input  mem_raddr,
    input  mem_renable,
    input  tile_bits,
    input  tile_valid
  );

  modport slave (
    input  top_left_corner_address,
    input  start_reading_tile,
    input  mem_rdata,
    output ready,
    output mem_raddr,
    output mem_renable,
    output tile_bits,
    output tile_valid
  );

endinterface

// File: rtl/tile_scan_counter.sv
// Row/column walker producing tile pixel addresses, one per advance.
// Ports: start loads base, advance steps, addr/idx current pixel, last at final pixel.
module tile_scan_counter
  import screen_pkg::*;
#(
  parameter int SCREEN_WIDTH = screen_pkg::SCREEN_WIDTH,
  parameter int CHAR_WIDTH   = screen_pkg::CHAR_WIDTH,
  parameter int CHAR_HEIGHT  = screen_pkg::CHAR_HEIGHT,
  localparam int CW = $clog2(CHAR_WIDTH),
  localparam int RW = $clog2(CHAR_HEIGHT),
  localparam int IW = $clog2(CHAR_WIDTH * CHAR_HEIGHT)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic          advance,
  input  addr_t         base,
  output addr_t         addr,
  output logic [IW-1:0] idx,
  output logic          last
);

  // Jump from the end of one tile row to the start of the next.
  localparam addr_t WRAP_STEP =
    addr_t'(SCREEN_WIDTH - (CHAR_WIDTH - 1));

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          row_end;

  assign row_end = (col == CW'(CHAR_WIDTH - 1));
  assign last    = row_end && (row == RW'(CHAR_HEIGHT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= '0;
      idx  <= '0;
      col  <= '0;
      row  <= '0;
    end else if (start) begin
      addr <= base;
      idx  <= '0;
      col  <= '0;
      row  <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
      if (row_end) begin
        col  <= '0;
        row  <= row + 1'b1;
        addr <= addr + WRAP_STEP;
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_reader.sv
// Reads a CHAR_WIDTH x CHAR_HEIGHT tile from the framebuffer into a bitmap.
// Ports: clock, resetn, bus (tile_reader_if.slave: start/ready, mem read, tile out).
module tile_reader
  import screen_pkg::*;
#(
  parameter int SCREEN_WIDTH = screen_pkg::SCREEN_WIDTH,
  parameter int CHAR_WIDTH   = screen_pkg::CHAR_WIDTH,
  parameter int CHAR_HEIGHT  = screen_pkg::CHAR_HEIGHT
) (
  input  logic          clock,
  input  logic          resetn,
  tile_reader_if.slave  bus
);

  localparam int N  = CHAR_WIDTH * CHAR_HEIGHT;
  localparam int IW = $clog2(N);

  rd_state_t     state, state_nx;
  addr_t         addr;
  logic [IW-1:0] idx;
  logic          last;
  logic          start;
  logic          advance;
  logic          cap_vld;
  logic [IW-1:0] cap_idx;
  logic [IW-1:0] cap_pos;
  logic [N-1:0]  tile_q;
  logic          unused_rdata;

  assign start   = (state == IDLE) && bus.start_reading_tile;
  assign advance = (state == READ) && !last;

  tile_scan_counter #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .CHAR_WIDTH   (CHAR_WIDTH),
    .CHAR_HEIGHT  (CHAR_HEIGHT)
  ) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .advance (advance),
    .base    (bus.top_left_corner_address),
    .addr    (addr),
    .idx     (idx),
    .last    (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start_reading_tile) state_nx = READ;
      READ:    if (last) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory answers one cycle after the address, so the issued pixel
  // index is delayed one cycle to line up with its data.
  assign cap_pos = IW'(N - 1) - cap_idx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cap_vld <= 1'b0;
      cap_idx <= '0;
      tile_q  <= '0;
    end else begin
      cap_vld <= (state == READ);
      cap_idx <= idx;
      if (cap_vld) tile_q[cap_pos] <= ~bus.mem_rdata[0];
    end
  end

  assign unused_rdata = ^bus.mem_rdata[2:1];

  assign bus.ready       = (state == IDLE);
  assign bus.mem_raddr   = addr;
  assign bus.mem_renable = (state == READ);
  assign bus.tile_valid  = (state == DONE);
  assign bus.tile_bits   = tile_q;

endmodule

// File: tb/tb_tile_reader.sv
// Randomized self-checking bench for tile_reader.
// Per-read model from address formula and memory contents; checked every cycle.
module tb_tile_reader;

  localparam int N  = 600;
  localparam int SW = 640;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tile_reader_if bus();

  tile_reader dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [2:0] mem [int unsigned];

  bit           busy   = 1'b0;
  int           rel    = 0;
  logic [18:0]  m_base = '0;
  logic [N-1:0] m_exp  = '0;
  logic [N-1:0] m_held = '0;

  function automatic logic [18:0] addr_of(input logic [18:0] b, input int k);
    logic [31:0] s;
    s = 32'(b) + 32'((k / 20) * SW) + 32'(k % 20);
    return s[18:0];
  endfunction

  function automatic logic [2:0] mem_at(input logic [18:0] a);
    int unsigned key;
    key = 32'(a);
    if (mem.exists(key)) return mem[key];
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: a read is a 602-cycle transaction from its accepting edge.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy   = 1'b0;
      rel    = 0;
      m_held = '0;
    end else if (busy) begin
      rel++;
      if (rel == 602) begin
        busy   = 1'b0;
        m_held = m_exp;
      end
    end else if (bus.start_reading_tile) begin
      logic [2:0] w;
      busy   = 1'b1;
      rel    = 0;
      m_base = bus.top_left_corner_address;
      for (int k = 0; k < N; k++) begin
        w = mem_at(addr_of(m_base, k));
        m_exp[N-1-k] = ~w[0];
      end
    end
  end

  // Synchronous framebuffer: data one cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_renable) bus.mem_rdata <= mem_at(bus.mem_raddr);
    else                 bus.mem_rdata <= 3'($urandom);
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (busy) begin
        chk("renable", N'(bus.mem_renable), N'(rel <= 599));
        if (rel <= 599)
          chk("raddr", N'(bus.mem_raddr), N'(addr_of(m_base, rel)));
        chk("ready_busy", N'(bus.ready), '0);
        chk("valid", N'(bus.tile_valid), N'(rel == 601));
        if (rel == 601) chk("tile", bus.tile_bits, m_exp);
        if (rel <= 1) chk("tile_hold_start", bus.tile_bits, m_held);
      end else begin
        chk("ready_idle", N'(bus.ready), N'(1));
        chk("renable_idle", N'(bus.mem_renable), '0);
        chk("valid_idle", N'(bus.tile_valid), '0);
        chk("tile_held", bus.tile_bits, m_held);
      end
    end
  end

  task automatic fill(input logic [18:0] b, input bit ones);
    for (int k = 0; k < N; k++)
      mem[32'(addr_of(b, k))] = ones ? 3'b111 : 3'($urandom);
  endtask

  task automatic start_read(input logic [18:0] b);
    @(negedge clk);
    bus.top_left_corner_address = b;
    bus.start_reading_tile      = 1'b1;
    @(negedge clk);
    bus.start_reading_tile      = 1'b0;
    bus.top_left_corner_address = 19'($urandom);
  endtask

  task automatic wait_idle(input bit poke);
    int n;
    n = 0;
    while (busy && n < 800) begin
      @(negedge clk);
      n++;
      if (poke && $urandom_range(0, 15) == 0) begin
        bus.start_reading_tile      = 1'b1;
        bus.top_left_corner_address = 19'($urandom);
      end else begin
        bus.start_reading_tile = 1'b0;
      end
    end
    bus.start_reading_tile = 1'b0;
    total++;
    if (busy) begin
      bad++;
      $display("FAIL timeout: busy after %0d cycles want idle", n);
    end
  endtask

  initial begin
    logic [N-1:0] pat;
    int           cnt;
    int           vat;
    int           pulses;
    logic [18:0]  b;

    bus.top_left_corner_address = '0;
    bus.start_reading_tile      = 1'b0;
    bus.mem_rdata               = '0;

    chk("pin_addr20", N'(addr_of(19'd64300, 20)), N'(19'd64940));
    chk("pin_addr599", N'(addr_of(19'd64300, 599)), N'(19'd82879));
    chk("pin_wrap", N'(addr_of(19'h7FFFF, 1)), '0);

    #1;
    chk("rst_ready", N'(bus.ready), N'(1));
    chk("rst_renable", N'(bus.mem_renable), '0);
    chk("rst_raddr", N'(bus.mem_raddr), '0);
    chk("rst_valid", N'(bus.tile_valid), '0);
    chk("rst_tile", bus.tile_bits, '0);
    #21 resetn = 1'b1;

    // Base 0 with a known pattern.
    for (int i = 0; i < N; i += 32) pat[i +: 32] = $urandom;
    for (int k = 0; k < N; k++)
      mem[32'(addr_of(19'd0, k))] = {2'($urandom), ~pat[N-1-k]};
    start_read(19'd0);
    cnt = 0;
    vat = -1;
    for (int j = 0; j < 604; j++) begin
      if (bus.mem_renable) cnt++;
      if (bus.tile_valid) vat = j;
      @(negedge clk);
    end
    chk("renable_cycles", N'(cnt), N'(600));
    chk("valid_cycle", N'(vat), N'(601));
    wait_idle(1'b0);
    chk("pattern", bus.tile_bits, pat);

    // Base 640*100+300.
    fill(19'd64300, 1'b0);
    start_read(19'd64300);
    chk("a0", N'(bus.mem_raddr), N'(19'd64300));
    repeat (19) @(negedge clk);
    chk("a19", N'(bus.mem_raddr), N'(19'd64319));
    @(negedge clk);
    chk("a20", N'(bus.mem_raddr), N'(19'd64940));
    repeat (579) @(negedge clk);
    chk("a599", N'(bus.mem_raddr), N'(19'd82879));
    wait_idle(1'b0);

    // Address wrap at the top of the space.
    fill(19'h7FFFF, 1'b0);
    start_read(19'h7FFFF);
    chk("wrap0", N'(bus.mem_raddr), N'(19'h7FFFF));
    @(negedge clk);
    chk("wrap1", N'(bus.mem_raddr), '0);
    wait_idle(1'b0);

    // Upper data bits set everywhere, bit0 set: empty tile.
    fill(19'd5000, 1'b1);
    start_read(19'd5000);
    wait_idle(1'b1);
    chk("ones_tile", bus.tile_bits, '0);

    // Start held high across reads.
    b = 19'($urandom);
    fill(b, 1'b0);
    @(negedge clk);
    bus.top_left_corner_address = b;
    bus.start_reading_tile      = 1'b1;
    pulses = 0;
    for (int j = 0; j < 1210; j++) begin
      @(negedge clk);
      if (bus.tile_valid) pulses++;
    end
    bus.start_reading_tile = 1'b0;
    chk("held_pulses", N'(pulses), N'(2));
    wait_idle(1'b0);

    // Reset in the middle of a read.
    b = 19'($urandom);
    fill(b, 1'b0);
    start_read(b);
    repeat (250) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_ready", N'(bus.ready), N'(1));
    chk("mid_renable", N'(bus.mem_renable), '0);
    chk("mid_raddr", N'(bus.mem_raddr), '0);
    chk("mid_valid", N'(bus.tile_valid), '0);
    chk("mid_tile", bus.tile_bits, '0);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    start_read(b);
    wait_idle(1'b0);

    // Random bases with stray starts while busy.
    for (int t = 0; t < 4; t++) begin
      b = 19'($urandom);
      fill(b, 1'b0);
      start_read(b);
      wait_idle(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
